cosine_sequencer: RTL and testbench

- FSM that drives the 3-bit state bus of the cosine/distance datapath (distance = v * cos(x) via Taylor-series term accumulation).
- Accepts a detection event, waits for a valid sensor sample and sequences load, NUM_TERMS accumulation cycles and the final distance multiply.
- Presents the result to the consumer through a valid/ack handshake.
- Sits between the sensor front-end and the datapath; it is the only driver of the datapath state bus.

---
 rtl/cosine_pkg.sv | 16 +
 rtl/cosine_term_counter.sv | 35 +++
 rtl/cosine_sequencer.sv | 129 ++++++++++++
 tb/tb_cosine_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosine_pkg.sv
// Shared definitions for the cosine/distance sequencer and its datapath.
// Both sides use the same state encoding.
package cosine_pkg;

  typedef enum logic [2:0] {
    STANDBY           = 3'd0,
    ALERT             = 3'd1,
    START_CALCULATION = 3'd2,
    ACCUMULATE_TERMS  = 3'd3,
    CALC_DISTANCE     = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_NUM_TERMS     = 6;
  localparam int unsigned DEFAULT_ALERT_TIMEOUT = 16;

endpackage

// File: rtl/cosine_term_counter.sv
// 3-bit Taylor-term index counter with sync clear, enable and a terminal flag
// raised on the last term (count == NUM_TERMS-1).
module cosine_term_counter
  import cosine_pkg::*;
#(
  parameter int unsigned NUM_TERMS = DEFAULT_NUM_TERMS
) (
  input  logic       clk,
  input  logic       asyncclear_n,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [2:0] o_count,
  output logic       o_terminal
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_TERMS - 1);

  logic [2:0] r_count;

  // Clear wins over enable; the count never wraps because the sequencer
  // clears it when leaving AccumulateTerms.
  always_ff @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 3'd1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == LAST_IDX);

endmodule

// File: rtl/cosine_sequencer.sv
// Sequencer driving the 3-bit state bus of the cosine/distance datapath:
// detect -> Alert (bounded wait for a sample) -> load -> NUM_TERMS term
// accumulations -> distance multiply, with a valid/ack result handshake.
module cosine_sequencer
  import cosine_pkg::*;
#(
  parameter int unsigned NUM_TERMS     = DEFAULT_NUM_TERMS,
  parameter int unsigned ALERT_TIMEOUT = DEFAULT_ALERT_TIMEOUT
) (
  input  logic       clk,
  input  logic       asyncclear_n,
  input  logic       detect,
  input  logic       sample_valid,
  input  logic       abort,
  input  logic       dp_done,
  input  logic       result_ack,
  output logic [2:0] state,
  output logic [2:0] term_idx,
  output logic       busy,
  output logic       result_valid,
  output logic       timeout
);

  localparam logic [7:0] ALERT_LAST = 8'(ALERT_TIMEOUT - 1);

  state_e     r_state;
  state_e     w_next_state;
  logic [7:0] r_alert_cnt;
  logic [7:0] w_next_alert_cnt;
  logic       r_timeout;
  logic       w_next_timeout;
  logic       r_busy;
  logic       r_result_valid;
  logic       w_next_result_valid;
  logic       r_rv_set;
  logic [2:0] w_term_count;
  logic       w_term_last;
  logic       w_term_clr;
  logic       w_term_en;

  // Term index runs only inside AccumulateTerms and is cleared on any exit,
  // so term_idx reads 0 everywhere else without extra output muxing.
  assign w_term_clr = (w_next_state != ACCUMULATE_TERMS);
  assign w_term_en  = (r_state == ACCUMULATE_TERMS);

  cosine_term_counter #(
    .NUM_TERMS (NUM_TERMS)
  ) u_term_counter (
    .clk          (clk),
    .asyncclear_n (asyncclear_n),
    .i_clr        (w_term_clr),
    .i_en         (w_term_en),
    .o_count      (w_term_count),
    .o_terminal   (w_term_last)
  );

  // Next-state, alert timer and timeout pulse; abort overrides everything.
  always_comb begin
    w_next_state     = r_state;
    w_next_alert_cnt = '0;
    w_next_timeout   = 1'b0;
    case (r_state)
      STANDBY: begin
        if (detect) w_next_state = ALERT;
      end
      ALERT: begin
        if (sample_valid) begin
          w_next_state = START_CALCULATION;
        end else if (r_alert_cnt == ALERT_LAST) begin
          w_next_state   = STANDBY;
          w_next_timeout = 1'b1;
        end else begin
          w_next_alert_cnt = r_alert_cnt + 8'd1;
        end
      end
      START_CALCULATION: w_next_state = ACCUMULATE_TERMS;
      ACCUMULATE_TERMS: begin
        if (w_term_last) w_next_state = CALC_DISTANCE;
      end
      CALC_DISTANCE: w_next_state = STANDBY;
      default:       w_next_state = STANDBY;
    endcase
    if (abort) begin
      w_next_state     = STANDBY;
      w_next_alert_cnt = '0;
      w_next_timeout   = 1'b0;
    end
  end

  // Result handshake: cleared on entry to StartCalculation or after an ack,
  // set once CalculateDistance completes without abort.
  always_comb begin
    w_next_result_valid = r_result_valid;
    if (r_result_valid && result_ack) w_next_result_valid = 1'b0;
    if (w_next_state == START_CALCULATION) w_next_result_valid = 1'b0;
    if (r_state == CALC_DISTANCE && !abort) w_next_result_valid = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) begin
      r_state        <= STANDBY;
      r_alert_cnt    <= '0;
      r_timeout      <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_rv_set       <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_alert_cnt    <= w_next_alert_cnt;
      r_timeout      <= w_next_timeout;
      r_busy         <= (w_next_state != STANDBY);
      r_result_valid <= w_next_result_valid;
      r_rv_set       <= (r_state == CALC_DISTANCE) && !abort;
    end
  end

  // The datapath must report Done in the cycle the result becomes valid.
  a_done_consistent : assert property (
    @(posedge clk) disable iff (!asyncclear_n) r_rv_set |-> dp_done
  );

  assign state        = r_state;
  assign term_idx     = w_term_count;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_cosine_sequencer.sv
// Directed bench for cosine_sequencer: default build plus a NUM_TERMS=1 build
// sharing the same stimulus.
module tb_cosine_sequencer;

  logic       clk;
  logic       asyncclear_n;
  logic       detect;
  logic       sample_valid;
  logic       abort;
  logic       dp_done;
  logic       dp_done1;
  logic       result_ack;
  logic [2:0] state, term_idx, state1, term_idx1;
  logic       busy, result_valid, timeout;
  logic       busy1, rv1, timeout1;

  int n_chk  = 0;
  int n_fail = 0;

  cosine_sequencer u_dut (
    .clk          (clk),
    .asyncclear_n (asyncclear_n),
    .detect       (detect),
    .sample_valid (sample_valid),
    .abort        (abort),
    .dp_done      (dp_done),
    .result_ack   (result_ack),
    .state        (state),
    .term_idx     (term_idx),
    .busy         (busy),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

  cosine_sequencer #(
    .NUM_TERMS (1)
  ) u_dut1 (
    .clk          (clk),
    .asyncclear_n (asyncclear_n),
    .detect       (detect),
    .sample_valid (sample_valid),
    .abort        (abort),
    .dp_done      (dp_done1),
    .result_ack   (result_ack),
    .state        (state1),
    .term_idx     (term_idx1),
    .busy         (busy1),
    .result_valid (rv1),
    .timeout      (timeout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath Done model: set by CalculateDistance, cleared by StartCalculation.
  always @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) dp_done <= 1'b0;
    else if (state == 3'd4) dp_done <= 1'b1;
    else if (state == 3'd2) dp_done <= 1'b0;
  end

  always @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) dp_done1 <= 1'b0;
    else if (state1 == 3'd4) dp_done1 <= 1'b1;
    else if (state1 == 3'd2) dp_done1 <= 1'b0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    asyncclear_n = 1'b1; detect = 1'b0; sample_valid = 1'b0;
    abort = 1'b0; result_ack = 1'b0;
    #2 asyncclear_n = 1'b0;
    #1;
    n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", state); end
    n_chk++; if (term_idx !== 3'd0) begin n_fail++; $display("FAIL rst_term_idx: got %0d exp 0", term_idx); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_result_valid: got %0b exp 0", result_valid); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %0b exp 0", timeout); end
    n_chk++; if (state1 !== 3'd0) begin n_fail++; $display("FAIL rst_state_n1: got %0d exp 0", state1); end
    repeat (2) tick;
    n_chk++; if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got state=%0d busy=%0b exp 0/0", state, busy); end
    @(negedge clk);
    asyncclear_n = 1'b1;
    tick;
    n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_release_state: got %0d exp 0", state); end
  endtask

  task automatic test_nominal;
    detect = 1'b1; tick; detect = 1'b0;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL nom_alert1: got %0d exp 1", state); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy: got %0b exp 1", busy); end
    tick;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL nom_alert2: got %0d exp 1", state); end
    tick;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL nom_alert3: got %0d exp 1", state); end
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL nom_start: got %0d exp 2", state); end
    n_chk++; if (term_idx !== 3'd0) begin n_fail++; $display("FAIL nom_start_term: got %0d exp 0", term_idx); end
    for (int i = 0; i < 6; i++) begin
      tick;
      n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL nom_accum_state[%0d]: got %0d exp 3", i, state); end
      n_chk++; if (term_idx !== 3'(i)) begin n_fail++; $display("FAIL nom_term_idx[%0d]: got %0d exp %0d", i, term_idx, i); end
    end
    tick;
    n_chk++; if (state !== 3'd4 || term_idx !== 3'd0) begin n_fail++; $display("FAIL nom_calc: got state=%0d term=%0d exp 4/0", state, term_idx); end
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL nom_rv_early: got %0b exp 0", result_valid); end
    tick;
    n_chk++; if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL nom_done_state: got state=%0d busy=%0b exp 0/0", state, busy); end
    n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL nom_rv_latency: got %0b exp 1", result_valid); end
    repeat (2) begin
      tick;
      n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL nom_rv_hold: got %0b exp 1", result_valid); end
    end
    result_ack = 1'b1; tick; result_ack = 1'b0;
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL nom_ack_clear: got %0b exp 0", result_valid); end
    n_chk++; if (rv1 !== 1'b0) begin n_fail++; $display("FAIL nom_ack_clear_n1: got %0b exp 0", rv1); end
  endtask

  task automatic test_timeout;
    detect = 1'b1; tick; detect = 1'b0;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL to_alert_entry: got %0d exp 1", state); end
    for (int i = 2; i <= 16; i++) begin
      tick;
      n_chk++; if (state !== 3'd1 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_alert_cycle[%0d]: got state=%0d timeout=%0b exp 1/0", i, state, timeout); end
    end
    tick;
    n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL to_return_state: got %0d exp 0", state); end
    n_chk++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %0b exp 1", timeout); end
    n_chk++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_rv_busy: got rv=%0b busy=%0b exp 0/0", result_valid, busy); end
    tick;
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %0b exp 0", timeout); end
  endtask

  task automatic test_simultaneous;
    detect = 1'b1; tick; detect = 1'b0;
    repeat (15) tick;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL sim_alert16: got %0d exp 1", state); end
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL sim_start: got %0d exp 2", state); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL sim_no_timeout: got %0b exp 0", timeout); end
    n_chk++; if (state1 !== 3'd2) begin n_fail++; $display("FAIL sim_start_n1: got %0d exp 2", state1); end
    tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd0) begin n_fail++; $display("FAIL sim_accum0: got %0d/%0d exp 3/0", state, term_idx); end
    n_chk++; if (state1 !== 3'd3 || term_idx1 !== 3'd0) begin n_fail++; $display("FAIL n1_accum: got %0d/%0d exp 3/0", state1, term_idx1); end
    tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd1) begin n_fail++; $display("FAIL sim_accum1: got %0d/%0d exp 3/1", state, term_idx); end
    n_chk++; if (state1 !== 3'd4 || term_idx1 !== 3'd0) begin n_fail++; $display("FAIL n1_calc: got %0d/%0d exp 4/0", state1, term_idx1); end
    tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd2) begin n_fail++; $display("FAIL sim_accum2: got %0d/%0d exp 3/2", state, term_idx); end
    n_chk++; if (state1 !== 3'd0 || rv1 !== 1'b1) begin n_fail++; $display("FAIL n1_result: got state=%0d rv=%0b exp 0/1", state1, rv1); end
    for (int i = 3; i < 6; i++) begin
      tick;
      n_chk++; if (term_idx !== 3'(i)) begin n_fail++; $display("FAIL sim_term_idx[%0d]: got %0d exp %0d", i, term_idx, i); end
    end
    tick;
    n_chk++; if (state !== 3'd4) begin n_fail++; $display("FAIL sim_calc: got %0d exp 4", state); end
    tick;
    n_chk++; if (state !== 3'd0 || result_valid !== 1'b1) begin n_fail++; $display("FAIL sim_result: got state=%0d rv=%0b exp 0/1", state, result_valid); end
    result_ack = 1'b1; tick; result_ack = 1'b0;
    n_chk++; if (result_valid !== 1'b0 || rv1 !== 1'b0) begin n_fail++; $display("FAIL sim_ack: got rv=%0b rv_n1=%0b exp 0/0", result_valid, rv1); end
  endtask

  task automatic test_abort;
    detect = 1'b1; tick; detect = 1'b0;
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL ab_start: got %0d exp 2", state); end
    repeat (4) tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd3) begin n_fail++; $display("FAIL ab_pre: got %0d/%0d exp 3/3", state, term_idx); end
    abort = 1'b1; tick; abort = 1'b0;
    n_chk++; if (state !== 3'd0 || term_idx !== 3'd0) begin n_fail++; $display("FAIL ab_accum_exit: got %0d/%0d exp 0/0", state, term_idx); end
    n_chk++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL ab_accum_flags: got busy=%0b rv=%0b exp 0/0", busy, result_valid); end
    tick;
    n_chk++; if (state !== 3'd0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL ab_accum_after: got state=%0d rv=%0b exp 0/0", state, result_valid); end
    result_ack = 1'b1; tick; result_ack = 1'b0;
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ab_ack_ignored: got %0b exp 0", result_valid); end
    n_chk++; if (rv1 !== 1'b0) begin n_fail++; $display("FAIL ab_ack_n1: got %0b exp 0", rv1); end
    detect = 1'b1; tick; detect = 1'b0;
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    repeat (6) tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd5) begin n_fail++; $display("FAIL ab_last_term: got %0d/%0d exp 3/5", state, term_idx); end
    tick;
    n_chk++; if (state !== 3'd4) begin n_fail++; $display("FAIL ab_calc: got %0d exp 4", state); end
    abort = 1'b1; tick; abort = 1'b0;
    n_chk++; if (state !== 3'd0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL ab_calc_exit: got state=%0d rv=%0b exp 0/0", state, result_valid); end
    tick;
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ab_calc_no_rv: got %0b exp 0", result_valid); end
    result_ack = 1'b1; tick; result_ack = 1'b0;
  endtask

  task automatic test_overlap;
    detect = 1'b1; tick; detect = 1'b0;
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    repeat (7) tick;
    tick;
    n_chk++; if (state !== 3'd0 || result_valid !== 1'b1) begin n_fail++; $display("FAIL ov_first: got state=%0d rv=%0b exp 0/1", state, result_valid); end
    detect = 1'b1; tick; detect = 1'b0;
    n_chk++; if (state !== 3'd1 || result_valid !== 1'b1) begin n_fail++; $display("FAIL ov_alert_keep: got state=%0d rv=%0b exp 1/1", state, result_valid); end
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    n_chk++; if (state !== 3'd2 || result_valid !== 1'b0) begin n_fail++; $display("FAIL ov_start_drop: got state=%0d rv=%0b exp 2/0", state, result_valid); end
    detect = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      n_chk++; if (state !== 3'd3 || term_idx !== 3'(i)) begin n_fail++; $display("FAIL ov_busy_detect[%0d]: got %0d/%0d exp 3/%0d", i, state, term_idx, i); end
    end
    detect = 1'b0;
    tick;
    n_chk++; if (state !== 3'd4) begin n_fail++; $display("FAIL ov_calc: got %0d exp 4", state); end
    tick;
    n_chk++; if (state !== 3'd0 || result_valid !== 1'b1) begin n_fail++; $display("FAIL ov_second: got state=%0d rv=%0b exp 0/1", state, result_valid); end
    tick;
    n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL ov_no_retrigger: got %0d exp 0", state); end
    result_ack = 1'b1; tick; result_ack = 1'b0;
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ov_ack: got %0b exp 0", result_valid); end
  endtask

  task automatic test_reset_mid;
    detect = 1'b1; tick; detect = 1'b0;
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    tick; tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd1) begin n_fail++; $display("FAIL rm_pre: got %0d/%0d exp 3/1", state, term_idx); end
    #2 asyncclear_n = 1'b0;
    #1;
    n_chk++; if (state !== 3'd0 || term_idx !== 3'd0) begin n_fail++; $display("FAIL rm_async_state: got %0d/%0d exp 0/0", state, term_idx); end
    n_chk++; if (busy !== 1'b0 || result_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rm_async_flags: got busy=%0b rv=%0b to=%0b exp 0/0/0", busy, result_valid, timeout); end
    n_chk++; if (state1 !== 3'd0 || rv1 !== 1'b0) begin n_fail++; $display("FAIL rm_async_n1: got state=%0d rv=%0b exp 0/0", state1, rv1); end
    @(negedge clk);
    asyncclear_n = 1'b1;
    tick;
    n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL rm_release: got %0d exp 0", state); end
    detect = 1'b1; tick; detect = 1'b0;
    n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL rm_alert: got %0d exp 1", state); end
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL rm_start: got %0d exp 2", state); end
    repeat (6) tick;
    n_chk++; if (state !== 3'd3 || term_idx !== 3'd5) begin n_fail++; $display("FAIL rm_last_term: got %0d/%0d exp 3/5", state, term_idx); end
    tick;
    n_chk++; if (state !== 3'd4) begin n_fail++; $display("FAIL rm_calc: got %0d exp 4", state); end
    tick;
    n_chk++; if (state !== 3'd0 || result_valid !== 1'b1) begin n_fail++; $display("FAIL rm_result: got state=%0d rv=%0b exp 0/1", state, result_valid); end
    result_ack = 1'b1; tick; result_ack = 1'b0;
    n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ack: got %0b exp 0", result_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_nominal;
    test_timeout;
    test_simultaneous;
    test_abort;
    test_overlap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
